// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: RED->GREEN->YELLOW light sequencer with a 1 s prescaler,
// pedestrian GREEN cut and a 2-digit BCD countdown of the seconds left in the phase.
module traffic_phase_scheduler #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int RED_S     = 10,
    parameter int GREEN_S   = 8,
    parameter int YELLOW_S  = 3,
    parameter int PED_CUT_S = 2
) (
    input  logic       fast_clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       ped_req,
    output logic [0:2] light,
    output logic       clock,
    output logic [1:0] phase,
    output logic [7:0] remain_bcd,
    output logic       ped_ack
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {RED = 2'b00, GREEN = 2'b01, YELLOW = 2'b10, BAD = 2'b11} phase_t;

    logic [PW-1:0] r_presc;
    phase_t        r_phase;
    logic [6:0]    r_remain;
    logic [0:2]    r_light;
    logic          r_clock;
    logic          r_pending;
    logic          r_ack;
    logic          w_tick;

    assign w_tick = enable && (r_presc == PW'(TICK_DIV - 1));

    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_phase   <= RED;
            r_remain  <= 7'(RED_S);
            r_light   <= 3'b100;
            r_clock   <= 1'b0;
            r_pending <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_clock   <= w_tick;
            r_ack     <= 1'b0;
            r_pending <= r_pending | ped_req;
            if (enable)
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (r_phase == BAD) begin
                r_phase  <= RED;
                r_remain <= 7'(RED_S);
                r_light  <= 3'b100;
            end else if (w_tick) begin
                if (r_remain == 7'd1) begin
                    case (r_phase)
                        RED: begin
                            r_phase  <= GREEN;
                            r_remain <= 7'(GREEN_S);
                            r_light  <= 3'b001;
                        end
                        GREEN: begin
                            r_phase  <= YELLOW;
                            r_remain <= 7'(YELLOW_S);
                            r_light  <= 3'b010;
                        end
                        default: begin
                            r_phase  <= RED;
                            r_remain <= 7'(RED_S);
                            r_light  <= 3'b100;
                            // a request arriving in the serving cycle counts as served too
                            if (r_pending) begin
                                r_pending <= 1'b0;
                                r_ack     <= 1'b1;
                            end
                        end
                    endcase
                end else if (r_phase == GREEN && r_pending && r_remain > 7'(PED_CUT_S)) begin
                    r_remain <= 7'(PED_CUT_S);
                end else begin
                    r_remain <= r_remain - 7'd1;
                end
            end
        end
    end

    assign light      = r_light;
    assign clock      = r_clock;
    assign phase      = r_phase;
    assign ped_ack    = r_ack;
    assign remain_bcd = {4'(r_remain / 7'd10), 4'(r_remain % 7'd10)};
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: scoreboarded cycle model of the scheduler plus directed checks,
// and a second instance with a 23 s RED to exercise BCD tens rollover.
module tb_traffic_phase_scheduler;
    localparam int TD = 4, RS = 5, GS = 4, YS = 2, PC = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       ped_req = 1'b0;
    logic [0:2] light;
    logic       clock;
    logic [1:0] phase;
    logic [7:0] remain_bcd;
    logic       ped_ack;
    logic [0:2] light23;
    logic       clock23;
    logic [1:0] phase23;
    logic [7:0] remain23;
    logic       ack23;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int m_presc, m_phase, m_remain;
    logic m_pending, m_clock, m_ack;
    logic [14:0] exp_q[$];
    logic [7:0]  q23[$];

    always #5 clk = ~clk;

    traffic_phase_scheduler #(.TICK_DIV(TD), .RED_S(RS), .GREEN_S(GS), .YELLOW_S(YS), .PED_CUT_S(PC)) u_dut (
        .fast_clk(clk), .rst_n(rst_n), .enable(enable), .ped_req(ped_req), .light(light),
        .clock(clock), .phase(phase), .remain_bcd(remain_bcd), .ped_ack(ped_ack)
    );

    traffic_phase_scheduler #(.TICK_DIV(2), .RED_S(23)) u_dut23 (
        .fast_clk(clk), .rst_n(rst_n), .enable(1'b1), .ped_req(1'b0), .light(light23),
        .clock(clock23), .phase(phase23), .remain_bcd(remain23), .ped_ack(ack23)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        int t = 0;
        while (v >= 10) begin
            v -= 10;
            t++;
        end
        return {t[3:0], v[3:0]};
    endfunction

    function automatic logic [2:0] light_of(input int p);
        return p == 0 ? 3'b100 : p == 1 ? 3'b001 : 3'b010;
    endfunction

    function automatic int dur(input int p);
        return p == 0 ? RS : p == 1 ? GS : YS;
    endfunction

    task automatic m_reset();
        m_presc = 0; m_phase = 0; m_remain = RS;
        m_pending = 0; m_clock = 0; m_ack = 0;
    endtask

    task automatic step(input logic en, input logic pr);
        logic tick, served;
        enable = en;
        ped_req = pr;
        tick = en && m_presc == TD - 1;
        served = 0;
        m_ack = 0;
        m_clock = tick;
        if (en) m_presc = tick ? 0 : m_presc + 1;
        if (tick) begin
            if (m_remain == 1) begin
                m_phase = (m_phase + 1) % 3;
                m_remain = dur(m_phase);
                if (m_phase == 0 && m_pending) begin
                    m_ack = 1;
                    served = 1;
                end
            end else if (m_phase == 1 && m_pending && m_remain > PC) begin
                m_remain = PC;
            end else begin
                m_remain--;
            end
        end
        m_pending = served ? 1'b0 : (m_pending | pr);
        exp_q.push_back({light_of(m_phase), 2'(m_phase), bcd(m_remain), m_clock, m_ack});
        @(posedge clk);
        #1;
        cyc++;
        check($sformatf("cyc%0d", cyc), {light, phase, remain_bcd, clock, ped_ack}, exp_q.pop_front());
    endtask

    always @(negedge clk)
        if (rst_n && clock23 && q23.size() > 0)
            check("bcd23", remain23, q23.pop_front());

    initial begin
        for (int v = 22; v >= 9; v--) q23.push_back(bcd(v));
        m_reset();
        #1 rst_n = 1'b0;
        #1;
        check("rst_async", {light, phase, remain_bcd, clock, ped_ack}, {3'b100, 2'b00, 8'h05, 2'b00});
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", {light, phase, remain_bcd, clock, ped_ack}, {3'b100, 2'b00, 8'h05, 2'b00});
        rst_n = 1'b1;
        for (int c = 1; c <= 127; c++) begin
            step(!(c >= 105 && c <= 114), c == 65);
            case (c)
                1:   begin check("rel_light", light, 3'b100); check("rel_bcd", remain_bcd, 8'h05); check("bcd23_init", remain23, 8'h23); end
                4:   begin check("tick1_clk", clock, 1'b1); check("tick1_bcd", remain_bcd, 8'h04); end
                5:   check("tick1_pulse", clock, 1'b0);
                20:  begin check("green_light", light, 3'b001); check("green_bcd", remain_bcd, 8'h04); end
                36:  begin check("yellow_light", light, 3'b010); check("yellow_bcd", remain_bcd, 8'h02); end
                44:  begin check("wrap_light", light, 3'b100); check("wrap_bcd", remain_bcd, 8'h05); end
                68:  begin check("ped_cut_bcd", remain_bcd, 8'h01); check("ped_cut_phase", phase, 2'b01); end
                72:  check("ped_yellow", light, 3'b010);
                80:  check("ped_ack_hi", ped_ack, 1'b1);
                81:  check("ped_ack_lo", ped_ack, 1'b0);
                104: begin check("pre_hold_bcd", remain_bcd, 8'h03); check("pre_hold_light", light, 3'b001); end
                114: begin check("hold_clk", clock, 1'b0); check("hold_bcd", remain_bcd, 8'h03); end
                117: begin check("resume_noclk", clock, 1'b0); check("resume_bcd3", remain_bcd, 8'h03); end
                118: begin check("resume_clk", clock, 1'b1); check("resume_bcd2", remain_bcd, 8'h02); end
                127: check("mid_yellow", light, 3'b010);
                default: ;
            endcase
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_mid", {light, phase, remain_bcd, clock, ped_ack}, {3'b100, 2'b00, 8'h05, 2'b00});
        m_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            step(1'b1, c == 3);
            case (c)
                24: begin check("redreq_cut", remain_bcd, 8'h01); check("redreq_phase", phase, 2'b01); end
                36: check("redreq_ack", ped_ack, 1'b1);
                default: ;
            endcase
        end
        check("q23_drain", q23.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
